// File: rtl/led_scan_if.sv
// Control and decoder-drive signals between the board-side controls and the LED scan sequencer.
interface led_scan_if;
   logic       start;
   logic       stop;
   logic       pause;
   logic [1:0] mode;
   logic [2:0] en_out;
   logic [2:0] sel_out;
   logic       busy;
   logic       wrap;

   modport master (output start, stop, pause, mode,
                   input  en_out, sel_out, busy, wrap);
   modport slave  (input  start, stop, pause, mode,
                   output en_out, sel_out, busy, wrap);
endinterface

// File: rtl/led_scan_ctrl.sv
// Running-light sequencer for a 3-to-8 active-low LED decoder: one LED lit at a time,
// programmable step rate, four scan modes, pause and stop.
//
// state   | meaning
// S_IDLE  | decoder disabled, prescaler cleared, waiting for start
// S_RUN   | LED lit, prescaler counting, sel steps on each tick
// S_PAUSE | LED lit, prescaler and sel frozen
module led_scan_ctrl #(
   parameter int TICK_DIV = 25_000_000,
   parameter int CNT_W    = 25
) (
   input  logic     clk,
   input  logic     rst,
   led_scan_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [1:0] M_UP = 2'b00, M_DOWN = 2'b01, M_PING = 2'b10, M_ONCE = 2'b11;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       sel_q, sel_d;
   logic             dir_q, dir_d;
   logic [1:0]       mode_q, mode_d;
   logic             wrap_q, wrap_d;
   logic [2:0]       en_q, en_d;
   logic             busy_q, busy_d;

   logic tick;
   logic once_done;

   assign tick      = (cnt_q == CNT_LAST);
   assign once_done = tick && (mode_q == M_ONCE) && (sel_q == 3'd7);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         sel_q   <= 3'd0;
         dir_q   <= 1'b0;
         mode_q  <= M_UP;
         wrap_q  <= 1'b0;
         en_q    <= 3'b000;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         dir_q   <= dir_d;
         mode_q  <= mode_d;
         wrap_q  <= wrap_d;
         en_q    <= en_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (!bus.stop && bus.start) state_d = S_RUN;
         S_RUN:   if (bus.stop || once_done)  state_d = S_IDLE;
                  else if (bus.pause)         state_d = S_PAUSE;
         S_PAUSE: if (bus.stop)               state_d = S_IDLE;
                  else if (!bus.pause)        state_d = S_RUN;
         default:                             state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cnt_d  = cnt_q;
      sel_d  = sel_q;
      dir_d  = dir_q;
      mode_d = mode_q;
      wrap_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (!bus.stop && bus.start) begin
               mode_d = bus.mode;
               sel_d  = (bus.mode == M_DOWN) ? 3'd7 : 3'd0;
               dir_d  = (bus.mode == M_DOWN);
            end
         end
         S_RUN: begin
            if (bus.stop) begin
               cnt_d = '0;
               sel_d = 3'd0;
            end else begin
               cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
               // a tick is applied even when pause is sampled on the same edge
               if (tick) begin
                  case (mode_q)
                     M_UP: begin
                        sel_d  = sel_q + 3'd1;
                        wrap_d = (sel_q == 3'd7);
                     end
                     M_DOWN: begin
                        sel_d  = sel_q - 3'd1;
                        wrap_d = (sel_q == 3'd0);
                     end
                     M_PING: begin
                        if (!dir_q && sel_q == 3'd7) begin
                           dir_d  = 1'b1;
                           sel_d  = 3'd6;
                           wrap_d = 1'b1;
                        end else if (dir_q && sel_q == 3'd0) begin
                           dir_d  = 1'b0;
                           sel_d  = 3'd1;
                           wrap_d = 1'b1;
                        end else begin
                           sel_d = dir_q ? sel_q - 3'd1 : sel_q + 3'd1;
                        end
                     end
                     default: begin
                        sel_d  = (sel_q == 3'd7) ? 3'd0 : sel_q + 3'd1;
                        wrap_d = (sel_q == 3'd7);
                        if (sel_q == 3'd7) cnt_d = '0;
                     end
                  endcase
               end
            end
         end
         S_PAUSE: begin
            if (bus.stop) begin
               cnt_d = '0;
               sel_d = 3'd0;
            end
         end
         default: begin
            cnt_d = '0;
            sel_d = 3'd0;
         end
      endcase
      busy_d = (state_d != S_IDLE);
      en_d   = (state_d != S_IDLE) ? 3'b100 : 3'b000;
   end

   assign bus.en_out  = en_q;
   assign bus.sel_out = sel_q;
   assign bus.busy    = busy_q;
   assign bus.wrap    = wrap_q;

endmodule
